uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between two byte requesters (port 0: CPU peripheral-write path,
//  port 1: hardware debug/result dumper). Round-robin grant, valid/ready handshake per port.
//  Sequences each byte: TX_EN launch pulse, then waits for TX_STATUS busy then idle; times out if never busy.
//  Sits between the memory-mapped UART controller/dumper and the UART sender.
// PARAMETERS
//  BUSY_TIMEOUT  16  max cycles in WAIT_BUSY before abort; range 2..65535
//  FIFO_DEPTH    8   entries in port-0 FIFO (power of 2, >=2); used only with UART_ARB_FIFO_EN
// PORTS
//  clk          in   1  single clock, all logic rising-edge
//  reset        in   1  synchronous, active-high
//  req0_valid   in   1  port 0 byte available
//  req0_data    in   8  port 0 byte
//  req0_ready   out  1  port 0 byte accepted this cycle when valid&ready
//  req1_valid   in   1  port 1 byte available
//  req1_data    in   8  port 1 byte
//  req1_ready   out  1  port 1 byte accepted this cycle when valid&ready
//  TX_STATUS    in   1  UART sender status: 1=idle, 0=busy
//  TX_EN        out  1  one-cycle launch pulse to sender
//  TX_DATA      out  8  byte to sender; stable from LAUNCH until next grant
//  grant_id     out  1  port of most recent grant
//  busy         out  1  1 whenever state != IDLE
//  timeout_err  out  1  sticky: a launch never saw TX_STATUS drop
//  err_clr      in   1  clears timeout_err
// BEHAVIOUR
//  Reset (sync): state=IDLE; TX_EN=0, TX_DATA=0, grant_id=0, timeout_err=0, rr pointer favours port 0,
//   timeout counter=0; FIFO (if present) emptied. Reset mid-transfer drops the in-flight byte; TX_EN low next edge.
//  FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: grant only if TX_STATUS=1 and a request is valid. reqN_ready combinational, high only for granted port
//   in IDLE. Both valid: grant port != grant_id of last grant (after reset: port 0). On grant: TX_DATA<=data,
//   grant_id<=port, -> LAUNCH. TX_STATUS=0 in IDLE: no grant, both ready low.
//  LAUNCH: TX_EN=1 for exactly this cycle; counter cleared; -> WAIT_BUSY.
//  WAIT_BUSY: TX_STATUS=0 -> WAIT_DONE. Else counter++; at counter==BUSY_TIMEOUT-1 -> timeout_err<=1, -> IDLE.
//  WAIT_DONE: TX_STATUS=1 -> IDLE (grant possible earliest the following cycle). No timeout here.
//  Latency: handshake at cycle N -> TX_EN high cycle N+1. Min 4 cycles between successive grants.
//  err_clr and timeout same cycle: set wins. Counter is $clog2(BUSY_TIMEOUT) bits, saturates, no wrap.
//  Outside IDLE both ready=0; valid/data may change freely, nothing sampled.
// CONFIGURATION
//  `UART_ARB_FIFO_EN defined: port 0 feeds a FIFO_DEPTH FIFO; req0_ready = !full (any state); arbiter treats
//   FIFO non-empty as port-0 request, pops head on grant. No bypass: byte pushed at N eligible for grant at N+1.
//   Push when full impossible (ready low). Simultaneous push+pop when full: pop only; when not full: both.
//   Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  Undefined: port 0 direct handshake identical to port 1; FIFO_DEPTH ignored.
// STRUCTURE
//  Package uart_arb_pkg: state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3),
//   TX_STATUS_IDLE=1'b1, port index constants.
//  One sub-module: uart_arb_fifo (sync FIFO, push/pop/full/empty/count), instantiated only under the macro.
// TESTING
//  1 Port 0 only, 0x55, sender model busy 2 cycles after TX_EN for 10 cycles -> req0_ready @N, TX_EN @N+1,
//    TX_DATA=0x55, busy low after TX_STATUS returns 1.
//  2 Both valid continuously, 0xA0/0xB1 -> grants alternate 0,1,0,1; TX_DATA sequence A0,B1,A0,B1; no dup/drop.
//  3 Sender ignores TX_EN, BUSY_TIMEOUT=16 -> IDLE 16 cycles after LAUNCH, timeout_err=1; err_clr -> 0;
//    err_clr on timeout cycle -> stays 1.
//  4 TX_STATUS held 0 in IDLE with valid high -> no ready, no TX_EN; release -> grant next cycle.
//  5 Reset asserted in WAIT_DONE -> next edge state IDLE, TX_EN=0, TX_DATA=0, grant_id=0, timeout_err=0.
//  6 With UART_ARB_FIFO_EN, FIFO_DEPTH=8: burst 10 bytes 0x00..0x09 on port 0 with stalled sender ->
//    ready drops after 8 accepted; release -> 0x00..0x09 transmitted in order.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e  : sequencer state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE)
//   - TxStatusIdle : TX_STATUS level meaning the sender is idle
//   - PortCpu/PortDbg : requester port indices
package uart_arb_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLaunch   = 2'd1,
      StWaitBusy = 2'd2,
      StWaitDone = 2'd3
   } arb_state_e;

   localparam logic TxStatusIdle = 1'b1;

   localparam logic PortCpu = 1'b0;  // CPU peripheral-write path
   localparam logic PortDbg = 1'b1;  // hardware debug/result dumper

endpackage

// File: rtl/uart_arb_fifo.sv
// Synchronous FIFO buffering port-0 bytes in front of the arbiter.
// Only instantiated when UART_ARB_FIFO_EN is defined.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i : write request and data (ignored when full)
//   pop_i              : remove head (ignored when empty)
//   pop_data_o         : head entry, valid when !empty_o
//   full_o, empty_o    : occupancy flags
//   count_o            : number of stored entries
module uart_arb_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_eff, pop_eff;

   assign full_o     = (count_q == CntW'(Depth));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // Push is dropped when full, so push+pop on a full FIFO reduces to pop only.
   assign push_eff = push_i & ~full_o;
   assign pop_eff  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-2 depth: wraps naturally
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_eff && !pop_eff) count_d = count_q + 1'b1;
      if (pop_eff && !push_eff) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte requesters with round-robin arbitration.
// Each granted byte is launched with a one-cycle TX_EN pulse; the sequencer then waits for
// TX_STATUS to go busy and back to idle, aborting with a sticky timeout_err if busy never shows.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   req0_valid/req0_data/req0_ready  : port 0 (CPU) byte handshake
//   req1_valid/req1_data/req1_ready  : port 1 (debug dumper) byte handshake
//   TX_STATUS                        : sender status, 1 = idle, 0 = busy
//   TX_EN, TX_DATA                   : launch pulse and byte to sender
//   grant_id                         : port of most recent grant
//   busy                             : sequencer not idle
//   timeout_err, err_clr             : sticky launch timeout flag and its clear
// Build option: define UART_ARB_FIFO_EN to buffer port 0 in a FIFO_DEPTH-entry FIFO.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned BUSY_TIMEOUT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   input  logic       TX_STATUS,
   output logic       TX_EN,
   output logic [7:0] TX_DATA,
   output logic       grant_id,
   output logic       busy,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam int unsigned CntW = $clog2(BUSY_TIMEOUT);
   localparam logic [CntW-1:0] CntMax = CntW'(BUSY_TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic            tx_en_q, tx_en_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            grant_id_q, grant_id_d;
   logic            rr_q, rr_d;        // port favoured when both request
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   logic            src0_valid;
   logic [7:0]      src0_data;
   logic            grant0, grant1;

`ifdef UART_ARB_FIFO_EN
   logic       fifo_full, fifo_empty;
   logic [7:0] fifo_data;

   uart_arb_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (8)
   ) u_fifo (
      .clk_i       (clk),
      .reset_i     (reset),
      .push_i      (req0_valid),
      .push_data_i (req0_data),
      .pop_i       (grant0),
      .pop_data_o  (fifo_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     ()
   );

   // No bypass: a byte pushed this cycle is only visible at the head next cycle.
   assign src0_valid = ~fifo_empty;
   assign src0_data  = fifo_data;
   assign req0_ready = ~fifo_full;
`else
   assign src0_valid = req0_valid;
   assign src0_data  = req0_data;
   assign req0_ready = grant0;
`endif

   assign req1_ready = grant1;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == StIdle && TX_STATUS == TxStatusIdle) begin
         if (src0_valid && req1_valid) begin
            if (rr_q == PortCpu) grant0 = 1'b1;
            else                 grant1 = 1'b1;
         end else if (src0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   always_comb begin
      logic err_set;
      err_set    = 1'b0;
      state_d    = state_q;
      tx_en_d    = 1'b0;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant0 || grant1) begin
               tx_en_d    = 1'b1;  // registered, so the pulse lands in LAUNCH
               tx_data_d  = grant1 ? req1_data : src0_data;
               grant_id_d = grant1 ? PortDbg : PortCpu;
               rr_d       = grant1 ? PortCpu : PortDbg;
               state_d    = StLaunch;
            end
         end
         StLaunch: begin
            cnt_d   = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (TX_STATUS != TxStatusIdle) begin
               state_d = StWaitDone;
            end else if (cnt_q == CntMax) begin
               err_set = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;  // never passes CntMax, so no wrap
            end
         end
         StWaitDone: begin
            if (TX_STATUS == TxStatusIdle) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Set has priority over clear.
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         tx_en_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         grant_id_q <= PortCpu;
         rr_q       <= PortCpu;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_en_q    <= tx_en_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign TX_EN       = tx_en_q;
   assign TX_DATA     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign busy        = (state_q != StIdle);
   assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model predicts every output each
// cycle, and directed scenarios add hand-computed literal checks.
module tb_uart_tx_arbiter;

   localparam int unsigned BT = 16;
   localparam int unsigned FD = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       tx_status;
   logic       TX_EN;
   logic [7:0] TX_DATA;
   logic       grant_id, busy, timeout_err, err_clr;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .BUSY_TIMEOUT (BT),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .TX_STATUS   (tx_status),
      .TX_EN       (TX_EN),
      .TX_DATA     (TX_DATA),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sender: mode 0 goes busy 2 cycles after TX_EN for 10 cycles, 1 never busy, 2 always busy.
   int snd_mode = 0;
   int snd_t = 0;
   always @(posedge clk) begin
      if (snd_t != 0)                    snd_t <= (snd_t >= 12) ? 0 : snd_t + 1;
      else if (TX_EN && snd_mode == 0)   snd_t <= 1;
   end
   assign tx_status = (snd_mode == 2) ? 1'b0 :
                      (snd_mode == 1) ? 1'b1 : !(snd_t >= 2 && snd_t < 12);

   // Transaction model: one byte in flight, tracked by time since launch and whether busy was seen.
   bit         m_busy, m_seen, m_gid, m_fav, m_err;
   int         m_since;
   logic [7:0] m_data;
   logic [7:0] m_q[$];

   function automatic void model_grant(output bit g, output bit gp);
      bit r0;
`ifdef UART_ARB_FIFO_EN
      r0 = (m_q.size() != 0);
`else
      r0 = (req0_valid === 1'b1);
`endif
      g  = !m_busy && (tx_status === 1'b1) && (r0 || req1_valid === 1'b1);
      gp = (r0 && req1_valid === 1'b1) ? m_fav : (req1_valid === 1'b1);
   endfunction

   always @(posedge clk) begin
      bit g, gp, set, full;
      model_grant(g, gp);
      full = (m_q.size() >= FD);
      set = 1'b0;
      if (reset) begin
         m_busy = 0; m_seen = 0; m_gid = 0; m_fav = 0; m_err = 0; m_since = 0; m_data = 8'h00;
         m_q.delete();
      end else begin
         if (g) begin
            m_busy = 1; m_since = 0; m_seen = 0; m_gid = gp; m_fav = !gp;
            if (gp) m_data = req1_data;
            else begin
`ifdef UART_ARB_FIFO_EN
               m_data = m_q.pop_front();
`else
               m_data = req0_data;
`endif
            end
         end else if (m_busy) begin
            if (m_since == 0) m_since = 1;
            else if (!m_seen) begin
               if (tx_status === 1'b0)  m_seen = 1;
               else if (m_since == BT)  begin set = 1; m_busy = 0; end
               else                     m_since++;
            end else if (tx_status === 1'b1) m_busy = 0;
         end
         if (set)                  m_err = 1;
         else if (err_clr === 1'b1) m_err = 0;
`ifdef UART_ARB_FIFO_EN
         if (req0_valid === 1'b1 && !full) m_q.push_back(req0_data);
`endif
      end
   end

   logic [7:0] log_data[$];
   bit         log_gid[$];
   int         txen_cyc = 0;

   always @(negedge clk) begin
      bit g, gp, e0;
      if (chk_en) begin
         model_grant(g, gp);
`ifdef UART_ARB_FIFO_EN
         e0 = (m_q.size() < FD);
`else
         e0 = g && !gp;
`endif
         check("req0_ready", req0_ready, e0);
         check("req1_ready", req1_ready, g && gp);
         check("TX_EN", TX_EN, m_busy && m_since == 0);
         check("TX_DATA", TX_DATA, m_data);
         check("grant_id", grant_id, m_gid);
         check("busy", busy, m_busy);
         check("timeout_err", timeout_err, m_err);
      end
      if (TX_EN === 1'b1) begin
         log_data.push_back(TX_DATA);
         log_gid.push_back(grant_id);
         txen_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < max) begin tick(); n++; end
      check(name, busy, 1'b0);
   endtask

   task automatic wait_snd_idle(input string name);
      int n = 0;
      while (tx_status !== 1'b1 && n < 50) begin tick(); n++; end
      check(name, tx_status, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      log_data.delete();
      log_gid.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; err_clr = 1'b0;
      req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b0; req1_data = 8'h00;
      repeat (2) tick();
      reset = 1'b0;
      chk_en = 1'b1;
      check("rst_TX_EN", TX_EN, 1'b0);
      check("rst_TX_DATA", TX_DATA, 8'h00);
      check("rst_grant_id", grant_id, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);

      // 1: single byte on port 0
      req0_valid = 1'b1; req0_data = 8'h55;
      #1;
      check("t1_ready0", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
`ifndef UART_ARB_FIFO_EN
      check("t1_TX_EN", TX_EN, 1'b1);
      check("t1_TX_DATA", TX_DATA, 8'h55);
`endif
      wait_idle(60, "t1_done");
      check("t1_status_idle", tx_status, 1'b1);
      check("t1_log", log_data.size() == 1 ? log_data[0] : 8'hxx, 8'h55);

`ifndef UART_ARB_FIFO_EN
      // 2: both ports continuously valid, alternate from port 0
      do_reset();
      wait_snd_idle("t2_snd_idle");
      req0_valid = 1'b1; req0_data = 8'hA0; req1_valid = 1'b1; req1_data = 8'hB1;
      n = 0;
      while (log_data.size() < 4 && n < 200) begin tick(); n++; end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("t2_count", log_data.size(), 4);
      if (log_data.size() >= 4) begin
         logic [7:0] exp_d [4];
         bit         exp_g [4];
         exp_d = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
         exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
         for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i), log_data[i], exp_d[i]);
            check($sformatf("t2_gid%0d", i), log_gid[i], exp_g[i]);
         end
      end
      wait_idle(60, "t2_done");
`endif

      // 3: sender ignores TX_EN -> timeout
      wait_snd_idle("t3_snd_idle");
      snd_mode = 1;
      req1_valid = 1'b1; req1_data = 8'h3C;
      tick();
      req1_valid = 1'b0;
      wait_idle(40, "t3_abort");
      check("t3_abort_cycle", cyc - txen_cyc, 17);
      check("t3_err_set", timeout_err, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t3_err_cleared", timeout_err, 1'b0);
      req1_valid = 1'b1; req1_data = 8'h3D;
      tick();
      req1_valid = 1'b0;
      repeat (16) tick();
      err_clr = 1'b1;  // coincides with the timeout
      tick();
      err_clr = 1'b0;
      check("t3_set_wins", timeout_err, 1'b1);
      check("t3_idle_again", busy, 1'b0);

      // 4: sender busy while idle blocks grants
      snd_mode = 2;
      req1_valid = 1'b1; req1_data = 8'h5A;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("t4_no_ready", req1_ready, 1'b0);
         check("t4_no_txen", TX_EN, 1'b0);
         tick();
      end
      snd_mode = 0;
      #1;
      check("t4_ready_on_release", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      check("t4_TX_EN", TX_EN, 1'b1);
      check("t4_TX_DATA", TX_DATA, 8'h5A);
      wait_idle(60, "t4_done");

      // 5: reset in WAIT_DONE (timeout_err still set from test 3)
      req1_valid = 1'b1; req1_data = 8'h77;
      tick();
      req1_valid = 1'b0;
      n = 0;
      while (tx_status !== 1'b0 && n < 20) begin tick(); n++; end
      repeat (2) tick();
      check("t5_in_flight", busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_busy", busy, 1'b0);
      check("t5_TX_EN", TX_EN, 1'b0);
      check("t5_TX_DATA", TX_DATA, 8'h00);
      check("t5_grant_id", grant_id, 1'b0);
      check("t5_timeout_err", timeout_err, 1'b0);
      wait_snd_idle("t5_snd_idle");

`ifdef UART_ARB_FIFO_EN
      // 6: burst of 10 bytes into the FIFO with a stalled sender
      begin
         int k = 0;
         do_reset();
         snd_mode = 2;
         for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b1; req0_data = k[7:0];
            #1;
            if (req0_ready) k++;
            tick();
         end
         check("t6_accepted_stalled", k, 8);
         snd_mode = 0;
         n = 0;
         while (k < 10 && n < 400) begin
            req0_valid = 1'b1; req0_data = k[7:0];
            #1;
            if (req0_ready) k++;
            tick(); n++;
         end
         req0_valid = 1'b0;
         check("t6_accepted_total", k, 10);
         n = 0;
         while (log_data.size() < 10 && n < 400) begin tick(); n++; end
         check("t6_sent", log_data.size(), 10);
         for (int i = 0; i < 10 && i < log_data.size(); i++)
            check($sformatf("t6_byte%0d", i), log_data[i], i);
         wait_idle(60, "t6_done");
      end
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
